unidade_controle_jogo: RTL
==========================

Name: unidade_controle_jogo

Overview:
- Moore FSM control unit for the memory-game datapath: address counter, expected-value memory, player-input register, comparator and the jogada edge detector.
- Each round: clears counter/register on start, waits for a play, registers it, compares it against memory, then advances or ends.
- Internal timeout counter ends the game if the player idles too long.
- Sits between the top-level game circuit and its datapath; drives debug state code to the 7-seg decoder.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed in ESPERA before timeout (must be >=2)
- TW, $clog2(TIMEOUT_CICLOS), width of internal timeout counter

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; forces INICIAL
- iniciar  in  1  start/restart request (level, sampled on clock)
- jogada  in  1  one-cycle pulse from datapath edge detector: a key was pressed
- igual  in  1  comparator: registered chaves == memory word
- fimC  in  1  address counter at last position (15)
- zeraC  out  1  synchronous clear of address counter
- contaC  out  1  increment address counter
- zeraR  out  1  clear player register
- registraR  out  1  load player register from chaves
- pronto  out  1  game finished (any end state)
- acertou  out  1  all 16 plays correct
- errou  out  1  wrong play
- timeout  out  1  player idle limit reached
- db_estado  out  4  state code for hex display

Behaviour:
- Reset (async): state=INICIAL, timeout counter=0; every output 0, db_estado=0x0.
- Outputs decoded from state only (Moore); no output depends on inputs combinationally.
- State codes: INICIAL=0x0, PREPARACAO=0x1, ESPERA=0x2, REGISTRA=0x4, COMPARACAO=0x5, PROXIMO=0x6, FIM_ACERTOU=0xA, FIM_TIMEOUT=0xD, FIM_ERROU=0xE. Any other code goes to INICIAL on the next clock.
- INICIAL: all outputs 0. iniciar=1 -> PREPARACAO, else stay.
- PREPARACAO (1 cycle): zeraC=1, zeraR=1. Always -> ESPERA.
- ESPERA: no datapath strobes; timeout counter increments each cycle.
  - jogada=1 -> REGISTRA.
  - Otherwise, when counter == TIMEOUT_CICLOS-1 -> FIM_TIMEOUT.
  - jogada has priority over a simultaneous timeout expiry.
- Timeout counter is held at 0 in every state except ESPERA. It therefore restarts for each play.
- REGISTRA (1 cycle): registraR=1. Always -> COMPARACAO.
- COMPARACAO (1 cycle), evaluated in this priority:
  - igual=0 -> FIM_ERROU.
  - igual=1 and fimC=1 -> FIM_ACERTOU.
  - igual=1 and fimC=0 -> PROXIMO.
- PROXIMO (1 cycle): contaC=1. Always -> ESPERA.
- End states:
  - FIM_ACERTOU: pronto=1, acertou=1.
  - FIM_ERROU: pronto=1, errou=1.
  - FIM_TIMEOUT: pronto=1, timeout=1.
  - Flags held while in state. iniciar=1 -> PREPARACAO (new game, counter/register cleared), else stay.
- iniciar is ignored in PREPARACAO..PROXIMO. jogada is ignored outside ESPERA.
- Latency: jogada pulse at edge N -> registraR high in cycle N+1 -> comparison in N+2 -> contaC or end state in N+3.
- Best case for a full game: 16 plays x 4 cycles plus PREPARACAO.
- At most one of acertou/errou/timeout is ever 1.
- Reset mid-game: immediate return to INICIAL, outputs 0 without waiting for a clock edge.

Decomposition:
- Shared package/include: the 4-bit state-code constants. The datapath hex decoder and the benches use the same codes.
- One sub-module: contador_timeout (parameterised up-counter with clear, enable and terminal-count flag at TIMEOUT_CICLOS-1).
- The FSM instantiates contador_timeout with enable=(state==ESPERA) and clear=(state!=ESPERA).

Test Plan:
- Reset, then iniciar=1 for 1 cycle -> db_estado 0x0, 0x1, 0x2. zeraC=zeraR=1 exactly one cycle in 0x1. Outputs otherwise 0.
- Bench TIMEOUT_CICLOS=10, 16 correct plays (jogada pulse, igual=1, fimC=1 on the 16th) -> 15 contaC pulses. db_estado ends at 0xA with pronto=acertou=1, errou=timeout=0.
- Third play with igual=0 -> exactly 2 contaC pulses, then db_estado=0xE, errou=1, pronto=1. A later jogada is ignored.
- No jogada for 10 cycles in ESPERA -> db_estado=0xD on cycle 10, timeout=pronto=1. jogada arriving on the expiry cycle -> REGISTRA (0x4) instead.
- In FIM_ERROU, pulse iniciar -> PREPARACAO with all end flags 0. Full correct game afterwards ends in 0xA.
- Assert reset while in COMPARACAO, between clock edges -> db_estado=0x0 and all outputs 0 before the next edge. The FSM stays in INICIAL until iniciar.

Source files
------------

// File: rtl/unidade_controle_jogo_pkg.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo_pkg
// State codes for the memory-game control unit. The same 4-bit codes feed the
// datapath hex decoder through db_estado, so they are part of the design's
// external contract and must not be renumbered.
// Also holds the Moore output bundle and its state->output decoder.
// -----------------------------------------------------------------------------
package unidade_controle_jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  typedef struct packed {
    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Moore decode: outputs depend on the state alone.
  function automatic saidas_t decodifica_saidas(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zeraC = 1'b1;
        s.zeraR = 1'b1;
      end
      REGISTRA:    s.registraR = 1'b1;
      PROXIMO:     s.contaC    = 1'b1;
      FIM_ACERTOU: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// -----------------------------------------------------------------------------
// contador_timeout
// Up-counter used to measure how long the player stays idle.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous active-high reset (count -> 0)
//   i_zera   synchronous clear (priority over i_conta)
//   i_conta  count enable
//   o_fim    high while the count equals TIMEOUT_CICLOS-1
// -----------------------------------------------------------------------------
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = $clog2(TIMEOUT_CICLOS)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim
);

  localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] r_cont;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cont <= '0;
    end else if (i_zera) begin
      r_cont <= '0;
    end else if (i_conta) begin
      r_cont <= r_cont + 1'b1;
    end
  end

  assign o_fim = (r_cont == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
// Moore FSM controlling the memory-game datapath: clears the address counter
// and player register at start, waits for each play, registers and compares
// it, then advances or ends the game (success, error or idle timeout).
// Ports:
//   clock, reset           clock (rising edge), async active-high reset
//   iniciar                start / restart request
//   jogada                 one-cycle key-press pulse
//   igual, fimC            comparator result, address counter at last word
//   zeraC, contaC          address counter clear / increment
//   zeraR, registraR       player register clear / load
//   pronto, acertou,
//   errou, timeout         end-of-game flags
//   db_estado              current state code for the hex display
// -----------------------------------------------------------------------------
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = $clog2(TIMEOUT_CICLOS)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t r_estado;
  estado_t w_prox;
  saidas_t r_saidas;
  logic    w_em_espera;
  logic    w_fim_tempo;

  assign w_em_espera = (r_estado == ESPERA);

  // Counter runs only while waiting for a play, so each play gets a fresh
  // idle budget.
  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .TW            (TW)
  ) u_contador_timeout (
    .i_clock(clock),
    .i_reset(reset),
    .i_zera (!w_em_espera),
    .i_conta(w_em_espera),
    .o_fim  (w_fim_tempo)
  );

  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:     w_prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  w_prox = ESPERA;
      // A key press wins over a timeout expiring in the same cycle.
      ESPERA:      w_prox = jogada      ? REGISTRA    :
                            w_fim_tempo ? FIM_TIMEOUT : ESPERA;
      REGISTRA:    w_prox = COMPARACAO;
      COMPARACAO:  w_prox = !igual ? FIM_ERROU   :
                            fimC   ? FIM_ACERTOU : PROXIMO;
      PROXIMO:     w_prox = ESPERA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT: w_prox = iniciar ? PREPARACAO : r_estado;
      default:     w_prox = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they always match the
  // state register and are cleared immediately by the async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_saidas <= '0;
    end else begin
      r_estado <= w_prox;
      r_saidas <= decodifica_saidas(w_prox);
    end
  end

  assign zeraC     = r_saidas.zeraC;
  assign contaC    = r_saidas.contaC;
  assign zeraR     = r_saidas.zeraR;
  assign registraR = r_saidas.registraR;
  assign pronto    = r_saidas.pronto;
  assign acertou   = r_saidas.acertou;
  assign errou     = r_saidas.errou;
  assign timeout   = r_saidas.timeout;
  assign db_estado = r_estado;

endmodule
